cpu_run_controller: RTL and testbench

- Synthesisable run and check sequencer for the single-cycle processor. Replaces the fixed "reset, then run 17 clocks" bench sequencing.
- It holds the processor in reset for a programmable number of cycles, then releases it and counts execution cycles.
- A run ends on either a halt (branch-to-self, i.e. PC stable) or a cycle budget timeout.
- At the end of a run it compares NUM_CHK watched register/memory values against expected values and reports pass/fail.

---
 rtl/cpu_run_controller_if.sv | 43 ++++
 rtl/cpu_run_controller.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if
//   Groups the connections between the run controller and its surroundings.
//   master : the host/bench side. It drives the run request, the processor PC
//            and the watched/expected words, and observes the results.
//   slave  : the controller side.
//   Signals:
//     start        one-cycle run request
//     PC           processor program counter
//     watch        NUM_CHK watched words, channel i at [i*DATA_W +: DATA_W]
//     expected     NUM_CHK expected words, same packing as watch
//     CPU_RST      active-high reset to the processor
//     busy/done    run in progress / results valid
//     pass, halted, timeout, fail_mask, cycle_count   run results
//     fsm_state    current controller state (debug visibility)
interface cpu_run_controller_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_CHK = 2,
  parameter int CNT_W   = 16
);
  logic                      start;
  logic [DATA_W-1:0]         PC;
  logic [NUM_CHK*DATA_W-1:0] watch;
  logic [NUM_CHK*DATA_W-1:0] expected;
  logic                      CPU_RST;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic                      halted;
  logic                      timeout;
  logic [NUM_CHK-1:0]        fail_mask;
  logic [CNT_W-1:0]          cycle_count;
  logic [2:0]                fsm_state;

  modport master (
    output start, PC, watch, expected,
    input  CPU_RST, busy, done, pass, halted, timeout, fail_mask, cycle_count, fsm_state
  );

  modport slave (
    input  start, PC, watch, expected,
    output CPU_RST, busy, done, pass, halted, timeout, fail_mask, cycle_count, fsm_state
  );
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run and check sequencer for the single-cycle processor. Holds the CPU in
//   reset for RESET_CYCLES cycles after a start request, releases it, counts
//   execution cycles until the PC stays put for HALT_REPEAT consecutive edges
//   (halt) or MAX_CYCLES elapse (timeout), snapshots the watched words on the
//   terminating edge, then compares them against the expected words.
//   Ports:
//     CLK   rising-edge clock
//     RST   synchronous active-low reset
//     bus   cpu_run_controller_if.slave (start, PC, watch, expected in;
//           CPU_RST, busy, done, pass, halted, timeout, fail_mask,
//           cycle_count, fsm_state out). All outputs are registered.
//   Handshake: start is a single-cycle request with no ready. It is accepted
//   only in IDLE or DONE and silently ignored in HOLD, RUN and CHECK.
module cpu_run_controller #(
  parameter int DATA_W       = 32,
  parameter int NUM_CHK      = 2,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 17,
  parameter int HALT_REPEAT  = 2
) (
  input logic                  CLK,
  input logic                  RST,
  cpu_run_controller_if.slave  bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SAME_W = $clog2(HALT_REPEAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [SAME_W-1:0] SAME_LIMIT = SAME_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      cpu_rst_q, cpu_rst_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic                      halted_q, halted_d;
  logic                      timeout_q, timeout_d;
  logic [NUM_CHK-1:0]        fail_q, fail_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [DATA_W-1:0]         prev_pc_q, prev_pc_d;
  logic [SAME_W-1:0]         same_q, same_d;
  logic [NUM_CHK*DATA_W-1:0] snap_q, snap_d;

  logic [NUM_CHK-1:0]        mismatch;
  logic [CNT_W-1:0]          cnt_inc;
  logic [SAME_W-1:0]         same_inc;
  logic                      halt_hit;
  logic                      budget_hit;

  // Per-channel comparison of the frozen snapshot against the live expected
  // words; only consumed in CHECK.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      mismatch[i] = (snap_q[i*DATA_W +: DATA_W] != bus.expected[i*DATA_W +: DATA_W]);
    end
  end

  // Values that the current RUN edge would produce. The same-PC counter never
  // needs to exceed HALT_REPEAT because reaching it ends the run.
  always_comb begin
    cnt_inc    = cnt_q + CNT_W'(1);
    same_inc   = (bus.PC == prev_pc_q) ? same_q + SAME_W'(1) : '0;
    halt_hit   = (same_inc == SAME_LIMIT);
    budget_hit = (cnt_inc == CNT_LIMIT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      prev_pc_q <= '0;
      same_q    <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      fail_q    <= fail_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      prev_pc_q <= prev_pc_d;
      same_q    <= same_d;
      snap_q    <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    prev_pc_d = prev_pc_q;
    same_d    = same_q;
    snap_d    = snap_q;

    case (state_q)
      S_IDLE: begin
        cpu_rst_d = 1'b1;
        if (bus.start) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          // Release the CPU; the PC seen on this edge is the reference for
          // the first RUN comparison.
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          cnt_d     = '0;
          same_d    = '0;
          prev_pc_d = bus.PC;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        cnt_d     = cnt_inc;
        same_d    = same_inc;
        prev_pc_d = bus.PC;
        // Halt takes priority when it coincides with the budget running out.
        if (halt_hit) begin
          halted_d = 1'b1;
          snap_d   = bus.watch;
          state_d  = S_CHECK;
        end else if (budget_hit) begin
          timeout_d = 1'b1;
          snap_d    = bus.watch;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        fail_d  = mismatch;
        pass_d  = (mismatch == '0) && !timeout_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          state_d   = S_HOLD;
          hold_d    = HOLD_LOAD;
          cpu_rst_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          fail_d    = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.CPU_RST     = cpu_rst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.fail_mask   = fail_q;
  assign bus.cycle_count = cnt_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
//   Directed bench for cpu_run_controller. Three instances share clock and
//   reset: dut_a (default parameters), dut_b (MAX_CYCLES=5, HALT_REPEAT=1)
//   and dut_c (RESET_CYCLES=3). The PC follows a simple processor model:
//   held at 0 during reset, then on run edge k it reads min(4*(k-1), stop).
module tb_cpu_run_controller;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_run_controller_if #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16)) ifa ();
  cpu_run_controller_if #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16)) ifb ();
  cpu_run_controller_if #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16)) ifc ();

  cpu_run_controller #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16), .RESET_CYCLES(1),
                       .MAX_CYCLES(17), .HALT_REPEAT(2))
    dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  cpu_run_controller #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16), .RESET_CYCLES(1),
                       .MAX_CYCLES(5), .HALT_REPEAT(1))
    dut_b (.CLK(clk), .RST(rst), .bus(ifb));
  cpu_run_controller #(.DATA_W(32), .NUM_CHK(2), .CNT_W(16), .RESET_CYCLES(3),
                       .MAX_CYCLES(17), .HALT_REPEAT(2))
    dut_c (.CLK(clk), .RST(rst), .bus(ifc));

  typedef struct packed {
    logic [31:0] pc_stop;
    logic [63:0] watch;
    logic [63:0] expv;
    logic        exp_halted;
    logic        exp_timeout;
    logic [15:0] exp_cc;
    logic [1:0]  exp_mask;
    logic        exp_pass;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc_at(input int k, input logic [31:0] stop);
    logic [31:0] v;
    v = 32'(4 * (k - 1));
    return (v < stop) ? v : stop;
  endfunction

  // Full run on dut_a for table row r, starting from IDLE or DONE.
  task automatic run_a(input int r);
    string t;
    t = $sformatf("row%0d", r);
    ifa.start    = 1'b1;
    ifa.PC       = 32'h0;
    ifa.watch    = vecs[r].watch;
    ifa.expected = ~vecs[r].expv;
    tick();
    ifa.start = 1'b0;
    chk({t, "_busy_hold"},    64'(ifa.busy),        64'(1));
    chk({t, "_cpurst_hold"},  64'(ifa.CPU_RST),     64'(1));
    chk({t, "_done_cleared"}, 64'(ifa.done),        64'(0));
    chk({t, "_cc_cleared"},   64'(ifa.cycle_count), 64'(0));
    tick();
    chk({t, "_cpurst_rel"}, 64'(ifa.CPU_RST), 64'(0));
    for (int k = 1; k <= 20; k++) begin
      ifa.PC = pc_at(k, vecs[r].pc_stop);
      tick();
      if (ifa.fsm_state != ST_RUN) break;
    end
    chk({t, "_state_check"}, 64'(ifa.fsm_state),   64'(ST_CHECK));
    chk({t, "_halted"},      64'(ifa.halted),      64'(vecs[r].exp_halted));
    chk({t, "_timeout"},     64'(ifa.timeout),     64'(vecs[r].exp_timeout));
    chk({t, "_cc"},          64'(ifa.cycle_count), 64'(vecs[r].exp_cc));
    chk({t, "_done_early"},  64'(ifa.done),        64'(0));
    // Watched values change after the terminating edge; expected becomes
    // correct only now.
    ifa.watch    = ~vecs[r].watch;
    ifa.expected = vecs[r].expv;
    tick();
    chk({t, "_done"},      64'(ifa.done),        64'(1));
    chk({t, "_busy_done"}, 64'(ifa.busy),        64'(0));
    chk({t, "_pass"},      64'(ifa.pass),        64'(vecs[r].exp_pass));
    chk({t, "_mask"},      64'(ifa.fail_mask),   64'(vecs[r].exp_mask));
    chk({t, "_cc_held"},   64'(ifa.cycle_count), 64'(vecs[r].exp_cc));
    ifa.PC = 32'h1234;
    tick();
    chk({t, "_done_hold"},   64'(ifa.fsm_state), 64'(ST_DONE));
    chk({t, "_cpurst_done"}, 64'(ifa.CPU_RST),   64'(0));
    chk({t, "_mask_hold"},   64'(ifa.fail_mask), 64'(vecs[r].exp_mask));
  endtask

  // Halting run on dut_c (RESET_CYCLES=3) with matching values.
  task automatic run_c(input string t);
    ifc.start    = 1'b1;
    ifc.PC       = 32'h0;
    ifc.watch    = {32'd13, 32'd7};
    ifc.expected = {32'd13, 32'd7};
    tick();
    ifc.start = 1'b0;
    chk({t, "_done_clr"}, 64'(ifc.done),        64'(0));
    chk({t, "_pass_clr"}, 64'(ifc.pass),        64'(0));
    chk({t, "_mask_clr"}, 64'(ifc.fail_mask),   64'(0));
    chk({t, "_cc_clr"},   64'(ifc.cycle_count), 64'(0));
    chk({t, "_busy"},     64'(ifc.busy),        64'(1));
    chk({t, "_cpurst_e1"}, 64'(ifc.CPU_RST),    64'(1));
    for (int e = 2; e <= 4; e++) begin
      tick();
      chk($sformatf("%s_cpurst_e%0d", t, e), 64'(ifc.CPU_RST), 64'((e < 4) ? 1 : 0));
    end
    for (int k = 1; k <= 20; k++) begin
      ifc.PC = pc_at(k, 32'h20);
      tick();
      if (ifc.fsm_state != ST_RUN) break;
    end
    chk({t, "_state_check"}, 64'(ifc.fsm_state),   64'(ST_CHECK));
    chk({t, "_halted"},      64'(ifc.halted),      64'(1));
    chk({t, "_timeout"},     64'(ifc.timeout),     64'(0));
    chk({t, "_cc"},          64'(ifc.cycle_count), 64'(11));
    tick();
    chk({t, "_done"}, 64'(ifc.done),      64'(1));
    chk({t, "_pass"}, 64'(ifc.pass),      64'(1));
    chk({t, "_mask"}, 64'(ifc.fail_mask), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             pc_stop        watch {ch1,ch0}                 expected {ch1,ch0}        H     T     cc      mask   pass
    vecs[0] = '{32'h20,       {32'd13, 32'd7},             {32'd13, 32'd7}, 1'b1, 1'b0, 16'd11, 2'b00, 1'b1};
    vecs[1] = '{32'h20,       {32'd13, 32'd7},             {32'd8,  32'd7}, 1'b1, 1'b0, 16'd11, 2'b10, 1'b0};
    vecs[2] = '{32'hFFFF_FF00, {32'd13, 32'd7},            {32'd13, 32'd7}, 1'b0, 1'b1, 16'd17, 2'b00, 1'b0};
    vecs[3] = '{32'h20,       {32'd13, 32'd7},             {32'd13, 32'd6}, 1'b1, 1'b0, 16'd11, 2'b01, 1'b0};
    vecs[4] = '{32'h08,       {32'hA5A5A5A5, 32'h5A5A5A5A}, {32'd0,  32'd0}, 1'b1, 1'b0, 16'd5,  2'b11, 1'b0};
    vecs[5] = '{32'h40,       {32'd1, 32'd2},              {32'd1,  32'd3}, 1'b0, 1'b1, 16'd17, 2'b01, 1'b0};
    vecs[6] = '{32'h38,       {32'd1, 32'd2},              {32'd1,  32'd2}, 1'b1, 1'b0, 16'd17, 2'b00, 1'b1};

    ifa.start = 1'b0; ifa.PC = '0; ifa.watch = '0; ifa.expected = '0;
    ifb.start = 1'b0; ifb.PC = '0; ifb.watch = '0; ifb.expected = '0;
    ifc.start = 1'b0; ifc.PC = '0; ifc.watch = '0; ifc.expected = '0;

    // Clock/reset block.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_a_state",  64'(ifa.fsm_state),   64'(ST_IDLE));
    chk("rst_a_cpurst", 64'(ifa.CPU_RST),     64'(1));
    chk("rst_a_busy",   64'(ifa.busy),        64'(0));
    chk("rst_a_done",   64'(ifa.done),        64'(0));
    chk("rst_a_pass",   64'(ifa.pass),        64'(0));
    chk("rst_a_cc",     64'(ifa.cycle_count), 64'(0));
    chk("rst_a_mask",   64'(ifa.fail_mask),   64'(0));
    chk("rst_b_cpurst", 64'(ifb.CPU_RST),     64'(1));
    chk("rst_c_cpurst", 64'(ifc.CPU_RST),     64'(1));
    tick();
    chk("idle_a_hold", 64'(ifa.fsm_state), 64'(ST_IDLE));

    // Table-driven runs; each row after the first restarts from DONE.
    for (int r = 0; r < 7; r++) begin
      run_a(r);
    end

    // dut_b: halt and budget coincide on the 5th run edge.
    ifb.start    = 1'b1;
    ifb.PC       = 32'h100;
    ifb.watch    = {32'd3, 32'd4};
    ifb.expected = {32'd3, 32'd4};
    tick();
    ifb.start = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      ifb.PC = pc_at(k, 32'd12);
      tick();
    end
    chk("b_state_run4", 64'(ifb.fsm_state),   64'(ST_RUN));
    chk("b_cc4",        64'(ifb.cycle_count), 64'(4));
    ifb.PC = pc_at(5, 32'd12);
    tick();
    chk("b_state_check", 64'(ifb.fsm_state),   64'(ST_CHECK));
    chk("b_halted",      64'(ifb.halted),      64'(1));
    chk("b_timeout",     64'(ifb.timeout),     64'(0));
    chk("b_cc",          64'(ifb.cycle_count), 64'(5));
    tick();
    chk("b_done", 64'(ifb.done), 64'(1));
    chk("b_pass", 64'(ifb.pass), 64'(1));

    // dut_a: start ignored in RUN, then reset mid-run.
    ifa.start = 1'b1;
    ifa.PC    = 32'h0;
    tick();
    ifa.start = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      ifa.PC = pc_at(k, 32'h20);
      tick();
    end
    chk("mid_cc3", 64'(ifa.cycle_count), 64'(3));
    ifa.PC    = pc_at(4, 32'h20);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("mid_start_ign_state", 64'(ifa.fsm_state),   64'(ST_RUN));
    chk("mid_start_ign_cc",    64'(ifa.cycle_count), 64'(4));
    chk("mid_start_ign_rst",   64'(ifa.CPU_RST),     64'(0));
    rst    = 1'b0;
    ifa.PC = pc_at(5, 32'h20);
    tick();
    rst = 1'b1;
    chk("mid_rst_state",  64'(ifa.fsm_state),   64'(ST_IDLE));
    chk("mid_rst_cpurst", 64'(ifa.CPU_RST),     64'(1));
    chk("mid_rst_cc",     64'(ifa.cycle_count), 64'(0));
    chk("mid_rst_done",   64'(ifa.done),        64'(0));
    chk("mid_rst_busy",   64'(ifa.busy),        64'(0));

    // dut_c: 3-cycle hold, then rerun from DONE with identical results.
    run_c("c1");
    tick();
    run_c("c2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
